// File: rtl/accum4_pkg.sv
// rtl/accum4_pkg.sv - shared state encodings and default parameters for the framed accumulator
package accum4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ACC_W  = 8;
    localparam int DEF_COUNT  = 4;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/accum4_frame_if.sv
// rtl/accum4_frame_if.sv - operand and result handshake bundle for accum4_frame
interface accum4_frame_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/accum4_add.sv
// rtl/accum4_add.sv - combinational accumulator adder with carry report and optional clamp
module accum4_add #(
    parameter int ACC_W = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] operand,
    output logic [ACC_W-1:0] next_acc,
    output logic             carry
);
    logic [ACC_W:0] full;

    always_comb begin
        full  = {1'b0, acc} + {1'b0, operand};
        carry = full[ACC_W];
        // once clamped at all-ones, any later carry keeps the value pinned there
        if (SAT && carry) begin
            next_acc = '1;
        end else begin
            next_acc = full[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/accum4_frame.sv
// rtl/accum4_frame.sv - sums COUNT operands per frame; ACCUM4_SATURATE_EN selects clamp instead of wrap
module accum4_frame
    import accum4_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int COUNT  = DEF_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    output logic                 busy,
    accum4_frame_if.slave        bus
);
`ifdef ACCUM4_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   add_base;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic               accept;

    assign bus.in_ready  = (state_q != DONE);
    assign bus.out_valid = (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;

    assign accept = bus.in_valid && bus.in_ready;

    // the first operand of a frame loads rather than adds
    assign add_base = (state_q == IDLE) ? '0 : acc_q;

    accum4_add #(
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_add (
        .acc      (add_base),
        .operand  (ACC_W'(bus.in_data)),
        .next_acc (add_sum),
        .carry    (add_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = add_sum;
                        cnt_d   = CNT_W'(1);
                        ovf_d   = add_carry;
                        state_d = (COUNT == 1) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_d = add_sum;
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | add_carry;
                        if (cnt_q == CNT_W'(COUNT - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_accum4_frame.sv
// tb/tb_accum4_frame.sv - randomized self-checking bench for accum4_frame (default and small-overflow configs)
module tb_accum4_frame;

    logic clk;
    logic rst;
    logic clr_a, clr_b;
    logic busy_a, busy_b;

    int checks;
    int failures;
    int cur;

    accum4_frame_if #(.DATA_W(4), .ACC_W(8)) ifa ();
    accum4_frame_if #(.DATA_W(4), .ACC_W(5)) ifb ();

    accum4_frame #(.DATA_W(4), .ACC_W(8), .COUNT(4)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .clear (clr_a),
        .busy  (busy_a),
        .bus   (ifa.slave)
    );

    accum4_frame #(.DATA_W(4), .ACC_W(5), .COUNT(3)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .clear (clr_b),
        .busy  (busy_b),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       obs_valid, obs_ready, obs_ovf, obs_busy;
    logic [7:0] obs_sum;

    always_comb begin
        obs_valid = (cur == 1) ? ifb.out_valid : ifa.out_valid;
        obs_ready = (cur == 1) ? ifb.in_ready  : ifa.in_ready;
        obs_ovf   = (cur == 1) ? ifb.out_ovf   : ifa.out_ovf;
        obs_busy  = (cur == 1) ? busy_b        : busy_a;
        obs_sum   = (cur == 1) ? {3'b000, ifb.out_sum} : ifa.out_sum;
    end

    // reference: a frame result is just the plain sum, folded by wrap or clamp
    function automatic int model_sum(input int total, input int accw);
        int lim;
        lim = 1 << accw;
`ifdef ACCUM4_SATURATE_EN
        return (total >= lim) ? lim - 1 : total;
`else
        return total % lim;
`endif
    endfunction

    function automatic logic model_ovf(input int total, input int accw);
        return total >= (1 << accw);
    endfunction

    task automatic push(input int sel, input logic [3:0] d);
        @(negedge clk);
        if (sel == 1) begin ifb.in_valid = 1'b1; ifb.in_data = d; end
        else          begin ifa.in_valid = 1'b1; ifa.in_data = d; end
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
    endtask

    task automatic drive_frame(input int sel, input int n, input int max_gap, output int total);
        total = 0;
        for (int i = 0; i < n; i++) begin
            int d;
            d = $urandom_range(15, 0);
            if (i > 0 && max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            push(sel, 4'(d));
            total += d;
        end
    endtask

    task automatic release_result(input int sel);
        @(negedge clk);
        if (sel == 1) ifb.out_ready = 1'b1; else ifa.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifa.out_ready = 1'b0;
        ifb.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        cur = 0;
        @(negedge clk);
        checks += 5;
        if (obs_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", obs_ready); end
        if (obs_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", obs_valid); end
        if (obs_sum !== 8'd0)   begin failures++; $display("FAIL reset_out_sum got=%0d exp=0", obs_sum); end
        if (obs_ovf !== 1'b0)   begin failures++; $display("FAIL reset_out_ovf got=%b exp=0", obs_ovf); end
        if (obs_busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", obs_busy); end
    endtask

    task automatic test_basic();
        cur = 0;
        ifa.out_ready = 1'b1;
        push(0, 4'd3); push(0, 4'd5); push(0, 4'd7); push(0, 4'd9);
        @(negedge clk);
        checks += 4;
        if (obs_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", obs_valid); end
        if (obs_sum !== 8'd24)  begin failures++; $display("FAIL basic_sum got=%0d exp=24", obs_sum); end
        if (obs_ovf !== 1'b0)   begin failures++; $display("FAIL basic_ovf got=%b exp=0", obs_ovf); end
        if (obs_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_done got=%b exp=0", obs_ready); end
        @(negedge clk);
        checks += 3;
        if (obs_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_after got=%b exp=0", obs_valid); end
        if (obs_busy !== 1'b0)  begin failures++; $display("FAIL basic_busy_after got=%b exp=0", obs_busy); end
        if (obs_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after got=%b exp=1", obs_ready); end
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        cur = 1;
        push(1, 4'd15); push(1, 4'd15); push(1, 4'd15);
        @(negedge clk);
        checks += 3;
        if (obs_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", obs_valid); end
        if (obs_sum !== 8'(model_sum(45, 5))) begin failures++; $display("FAIL ovf_sum got=%0d exp=%0d", obs_sum, model_sum(45, 5)); end
        if (obs_ovf !== 1'b1)   begin failures++; $display("FAIL ovf_flag got=%b exp=1", obs_ovf); end
        release_result(1);
        @(negedge clk);
        checks++;
        if (obs_ovf !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", obs_ovf); end
    endtask

    task automatic test_backpressure();
        int total;
        logic [7:0] exp_s;
        cur = 0;
        drive_frame(0, 4, 0, total);
        exp_s = 8'(model_sum(total, 8));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (obs_valid !== 1'b1 || obs_sum !== exp_s || obs_ovf !== 1'b0 || obs_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got v=%b s=%0d o=%b r=%b exp v=1 s=%0d o=0 r=0",
                         c, obs_valid, obs_sum, obs_ovf, obs_ready, exp_s);
            end
        end
        release_result(0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (obs_valid !== 1'b0) begin failures++; $display("FAIL bp_single_handshake cycle=%0d got=%b exp=0", c, obs_valid); end
        end
    endtask

    task automatic test_gapped();
        cur = 0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) begin
                repeat (2) begin
                    @(negedge clk);
                    checks++;
                    if (obs_valid !== 1'b0) begin failures++; $display("FAIL gap_no_early_valid op=%0d got=%b exp=0", i, obs_valid); end
                end
            end
            push(0, 4'(i));
        end
        @(negedge clk);
        checks += 2;
        if (obs_valid !== 1'b1) begin failures++; $display("FAIL gap_valid got=%b exp=1", obs_valid); end
        if (obs_sum !== 8'd10)  begin failures++; $display("FAIL gap_sum got=%0d exp=10", obs_sum); end
        release_result(0);
    endtask

    task automatic test_abort();
        cur = 0;
        push(0, 4'd6); push(0, 4'd2);
        @(negedge clk);
        ifa.in_valid = 1'b1; ifa.in_data = 4'd7; clr_a = 1'b1;
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0; clr_a = 1'b0;
        @(negedge clk);
        checks += 2;
        if (obs_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", obs_busy); end
        if (obs_sum !== 8'd0)  begin failures++; $display("FAIL abort_sum_zero got=%0d exp=0", obs_sum); end
        push(0, 4'd1); push(0, 4'd1); push(0, 4'd1); push(0, 4'd1);
        @(negedge clk);
        checks += 2;
        if (obs_valid !== 1'b1) begin failures++; $display("FAIL abort_next_valid got=%b exp=1", obs_valid); end
        if (obs_sum !== 8'd4)   begin failures++; $display("FAIL abort_next_sum got=%0d exp=4", obs_sum); end
        release_result(0);
    endtask

    task automatic test_reset_mid();
        int total;
        cur = 0;
        push(0, 4'd9); push(0, 4'd8); push(0, 4'd7);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (obs_busy !== 1'b0)  begin failures++; $display("FAIL rstmid_busy got=%b exp=0", obs_busy); end
        if (obs_sum !== 8'd0)   begin failures++; $display("FAIL rstmid_sum got=%0d exp=0", obs_sum); end
        if (obs_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", obs_ready); end
        if (obs_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", obs_valid); end
        @(negedge clk);
        rst = 1'b0;
        drive_frame(0, 4, 1, total);
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b1 || obs_sum !== 8'(model_sum(total, 8))) begin
            failures++;
            $display("FAIL rstmid_next_frame got v=%b s=%0d exp v=1 s=%0d", obs_valid, obs_sum, model_sum(total, 8));
        end
        release_result(0);
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        cur = 0;
        ifa.out_ready = 1'b1;
        drive_frame(0, 4, 0, t1);
        @(negedge clk);
        checks += 2;
        if (obs_sum !== 8'(model_sum(t1, 8))) begin failures++; $display("FAIL b2b_first_sum got=%0d exp=%0d", obs_sum, model_sum(t1, 8)); end
        if (obs_ready !== 1'b0) begin failures++; $display("FAIL b2b_handshake_ready got=%b exp=0", obs_ready); end
        drive_frame(0, 4, 0, t2);
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b1 || obs_sum !== 8'(model_sum(t2, 8))) begin
            failures++;
            $display("FAIL b2b_second got v=%b s=%0d exp v=1 s=%0d", obs_valid, obs_sum, model_sum(t2, 8));
        end
        @(negedge clk);
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 24; f++) begin
            int sel, n, accw, total;
            logic [7:0] exp_s;
            logic exp_o;
            sel  = f % 2;
            n    = (sel == 1) ? 3 : 4;
            accw = (sel == 1) ? 5 : 8;
            cur  = sel;
            drive_frame(sel, n, 2, total);
            exp_s = 8'(model_sum(total, accw));
            exp_o = model_ovf(total, accw);
            repeat ($urandom_range(3, 1)) begin
                @(negedge clk);
                checks++;
                if (obs_valid !== 1'b1 || obs_sum !== exp_s || obs_ovf !== exp_o) begin
                    failures++;
                    $display("FAIL rand_frame f=%0d got v=%b s=%0d o=%b exp v=1 s=%0d o=%b",
                             f, obs_valid, obs_sum, obs_ovf, exp_s, exp_o);
                end
            end
            release_result(sel);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cur      = 0;
        rst      = 1'b1;
        clr_a    = 1'b0;
        clr_b    = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_gapped();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
